// File: rtl/bip_pkg.sv
// Shared opcode and state definitions for the fetch controller and decoder.
package bip_pkg;

  // Defined opcodes; anything above OP_LAST is undefined and halts the CPU.
  localparam logic [4:0] HALT    = 5'b00000;
  localparam logic [4:0] STO     = 5'b00001;
  localparam logic [4:0] LD      = 5'b00010;
  localparam logic [4:0] LDI     = 5'b00011;
  localparam logic [4:0] ADD     = 5'b00100;
  localparam logic [4:0] ADDI    = 5'b00101;
  localparam logic [4:0] SUB     = 5'b00110;
  localparam logic [4:0] SUBI    = 5'b00111;
  localparam logic [4:0] OP_LAST = 5'd7;

  // Fetch sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

endpackage

// File: rtl/bip_pc.sv
// Program counter: synchronous clear, increment enable, wraps modulo 2^PC_W.
module bip_pc #(
  parameter int PC_W = 11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            inc,
  output logic [PC_W-1:0] pc
);

  // Clear wins over increment; natural overflow gives the all-ones -> 0 wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
    end else if (clr) begin
      pc <= '0;
    end else if (inc) begin
      pc <= pc + PC_W'(1);
    end
  end

endmodule

// File: rtl/bip_fetch_ctrl.sv
// Fetch/sequencing stage: PC, IR, executed-instruction counter and the
// IDLE/FETCH/DECODE/EXEC/HALT sequencer in front of the instruction decoder.
//
// Handshakes: o_rd_en is a one-cycle read request to a synchronous memory;
// i_instr is taken exactly one cycle later (DECODE). o_valid is a one-cycle
// pulse in EXEC; i_WrPC is only looked at while o_valid is high.
module bip_fetch_ctrl
  import bip_pkg::*;
#(
  parameter int N_OP      = 5,
  parameter int N_OPERAND = 11,
  parameter int PC_W      = 11,
  parameter int CNT_W     = 16
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_start,
  input  logic [N_OP+N_OPERAND-1:0] i_instr,
  input  logic                      i_WrPC,
  output logic [PC_W-1:0]           o_pc_addr,
  output logic                      o_rd_en,
  output logic [N_OP-1:0]           o_OPcode,
  output logic [N_OPERAND-1:0]      o_operand,
  output logic                      o_valid,
  output logic                      o_halted,
  output logic                      o_illegal,
  output logic [CNT_W-1:0]          o_instr_count,
  output logic [2:0]                o_state
);

  state_t                    state;
  logic [N_OP+N_OPERAND-1:0] ir;
  logic [CNT_W-1:0]          count;
  logic [N_OP-1:0]           op;
  logic                      op_halt;
  logic                      op_defined;
  logic                      start_ok;
  logic                      pc_clr;
  logic                      pc_inc;

  // Opcode classification of the instruction currently in the IR.
  always_comb begin
    op         = ir[N_OP+N_OPERAND-1:N_OPERAND];
    op_halt    = (op == N_OP'(HALT));
    op_defined = !op_halt && (op <= N_OP'(OP_LAST));
    start_ok   = i_start && ((state == ST_IDLE) || (state == ST_HALT));
    pc_clr     = start_ok;
    pc_inc     = (state == ST_EXEC) && op_defined && i_WrPC;
  end

  bip_pc #(
    .PC_W(PC_W)
  ) u_pc (
    .clk (i_clk),
    .rst (i_reset),
    .clr (pc_clr),
    .inc (pc_inc),
    .pc  (o_pc_addr)
  );

  // Sequencer with IR, counter and registered strobes/status.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= ST_IDLE;
      ir        <= '0;
      count     <= '0;
      o_rd_en   <= 1'b0;
      o_valid   <= 1'b0;
      o_halted  <= 1'b0;
      o_illegal <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_HALT: begin
          if (start_ok) begin
            ir        <= '0;
            count     <= '0;
            o_illegal <= 1'b0;
            o_halted  <= 1'b0;
            o_rd_en   <= 1'b1;
            state     <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          o_rd_en <= 1'b0;
          state   <= ST_DECODE;
        end
        ST_DECODE: begin
          ir      <= i_instr;
          o_valid <= 1'b1;
          state   <= ST_EXEC;
        end
        ST_EXEC: begin
          o_valid <= 1'b0;
          if (op_defined) begin
            // Count saturates rather than wrapping; PC handled by bip_pc.
            if (count != '1) count <= count + CNT_W'(1);
            o_rd_en <= 1'b1;
            state   <= ST_FETCH;
          end else begin
            if (!op_halt) o_illegal <= 1'b1;
            o_halted <= 1'b1;
            state    <= ST_HALT;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_OPcode      = op;
  assign o_operand     = ir[N_OPERAND-1:0];
  assign o_instr_count = count;
  assign o_state       = state;

endmodule

// File: tb/tb_bip_fetch_ctrl.sv
// Directed bench for bip_fetch_ctrl: main instance with a program memory
// model, plus two small instances (PC_W=3) for PC wrap and count saturation.
module tb_bip_fetch_ctrl;
  import bip_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic        wr_pc;
  logic [15:0] rdata;
  logic [10:0] pc_addr;
  logic        rd_en;
  logic [4:0]  opcode;
  logic [10:0] operand;
  logic        valid;
  logic        halted;
  logic        illegal;
  logic [15:0] count;
  logic [2:0]  state;

  logic [15:0] mem [0:2047];

  // Small instances: every word is ADDI 1, PC always written.
  logic        start_s;
  logic [15:0] word_s;
  logic [2:0]  pc_w, pc_s;
  logic        rd_en_w, rd_en_s, valid_w, valid_s, halted_w, halted_s;
  logic        illegal_w, illegal_s;
  logic [4:0]  opcode_w, opcode_s;
  logic [10:0] operand_w, operand_s;
  logic [15:0] cnt_w;
  logic [1:0]  cnt_s;
  logic [2:0]  state_w, state_s;

  int n_pass = 0;
  int n_total = 0;

  bip_fetch_ctrl dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_instr(rdata), .i_WrPC(wr_pc),
    .o_pc_addr(pc_addr), .o_rd_en(rd_en), .o_OPcode(opcode), .o_operand(operand),
    .o_valid(valid), .o_halted(halted), .o_illegal(illegal),
    .o_instr_count(count), .o_state(state)
  );

  bip_fetch_ctrl #(.PC_W(3), .CNT_W(16)) dut_w (
    .i_clk(clk), .i_reset(rst), .i_start(start_s), .i_instr(word_s), .i_WrPC(1'b1),
    .o_pc_addr(pc_w), .o_rd_en(rd_en_w), .o_OPcode(opcode_w), .o_operand(operand_w),
    .o_valid(valid_w), .o_halted(halted_w), .o_illegal(illegal_w),
    .o_instr_count(cnt_w), .o_state(state_w)
  );

  bip_fetch_ctrl #(.PC_W(3), .CNT_W(2)) dut_s (
    .i_clk(clk), .i_reset(rst), .i_start(start_s), .i_instr(word_s), .i_WrPC(1'b1),
    .o_pc_addr(pc_s), .o_rd_en(rd_en_s), .o_OPcode(opcode_s), .o_operand(operand_s),
    .o_valid(valid_s), .o_halted(halted_s), .o_illegal(illegal_s),
    .o_instr_count(cnt_s), .o_state(state_s)
  );

  // Clock and synchronous program memory (data one cycle after rd_en).
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) rdata <= mem[pc_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; wr_pc = 1'b1; start_s = 1'b0;
    word_s = {ADDI, 11'd1};
    rdata = 16'h0000;
    clear_mem();
    tick(); tick();
    chk("rst_state", 32'(state), 32'(ST_IDLE));
    chk("rst_pc", 32'(pc_addr), 0);
    chk("rst_rd_en", 32'(rd_en), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_illegal", 32'(illegal), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_opcode", 32'(opcode), 0);
    chk("rst_operand", 32'(operand), 0);
    rst = 1'b0;
    tick();
    chk("idle_quiet", 32'({rd_en, valid, halted}), 0);

    // Straight-line program: LDI 5, ADDI 3, HALT. start stays high through
    // FETCH/DECODE/EXEC to show it is ignored there.
    mem[0] = {LDI, 11'd5};
    mem[1] = {ADDI, 11'd3};
    mem[2] = {HALT, 11'd0};
    start = 1'b1;
    tick();                                   // cycle 1
    chk("a1_state", 32'(state), 32'(ST_FETCH));
    chk("a1_rd_en", 32'(rd_en), 1);
    chk("a1_pc", 32'(pc_addr), 0);
    tick();                                   // cycle 2
    chk("a2_state", 32'(state), 32'(ST_DECODE));
    chk("a2_rd_en", 32'(rd_en), 0);
    chk("a2_valid", 32'(valid), 0);
    tick();                                   // cycle 3
    chk("a3_valid", 32'(valid), 1);
    chk("a3_opcode", 32'(opcode), 3);
    chk("a3_operand", 32'(operand), 5);
    start = 1'b0;
    tick();                                   // cycle 4
    chk("a4_state", 32'(state), 32'(ST_FETCH));
    chk("a4_pc", 32'(pc_addr), 1);
    chk("a4_count", 32'(count), 1);
    chk("a4_valid", 32'(valid), 0);
    chk("a4_opcode_stable", 32'(opcode), 3);
    tick(); tick();                           // cycle 6
    chk("a6_valid", 32'(valid), 1);
    chk("a6_opcode", 32'(opcode), 5);
    chk("a6_operand", 32'(operand), 3);
    tick();                                   // cycle 7
    chk("a7_pc", 32'(pc_addr), 2);
    tick(); tick();                           // cycle 9
    chk("a9_valid", 32'(valid), 1);
    chk("a9_opcode", 32'(opcode), 0);
    tick();                                   // cycle 10
    chk("a10_halted", 32'(halted), 1);
    chk("a10_valid", 32'(valid), 0);
    chk("a10_state", 32'(state), 32'(ST_HALT));
    chk("a10_count", 32'(count), 2);
    chk("a10_pc", 32'(pc_addr), 2);
    chk("a10_illegal", 32'(illegal), 0);
    tick(); tick();
    chk("a12_frozen", 32'({halted, count}), 32'({1'b1, 16'd2}));

    // Hold: WrPC low for the first EXEC re-fetches address 0.
    clear_mem();
    mem[0] = {LDI, 11'd7};
    mem[1] = {HALT, 11'd0};
    start = 1'b1;
    tick();                                   // cycle 1
    start = 1'b0;
    chk("b1_state", 32'(state), 32'(ST_FETCH));
    chk("b1_count_clr", 32'(count), 0);
    chk("b1_pc_clr", 32'(pc_addr), 0);
    chk("b1_halted", 32'(halted), 0);
    tick(); tick();                           // cycle 3
    chk("b3_valid", 32'(valid), 1);
    wr_pc = 1'b0;
    tick();                                   // cycle 4
    wr_pc = 1'b1;
    chk("b4_state", 32'(state), 32'(ST_FETCH));
    chk("b4_pc_held", 32'(pc_addr), 0);
    chk("b4_count", 32'(count), 1);
    tick(); tick();                           // cycle 6
    chk("b6_opcode", 32'(opcode), 3);
    chk("b6_operand", 32'(operand), 7);
    tick();                                   // cycle 7
    chk("b7_pc", 32'(pc_addr), 1);
    chk("b7_count", 32'(count), 2);
    tick(); tick(); tick();                   // cycle 10
    chk("b10_halted", 32'(halted), 1);
    chk("b10_count", 32'(count), 2);

    // Undefined opcode 5'b01010 at word 1, then restart from HALT.
    clear_mem();
    mem[0] = {ADDI, 11'd1};
    mem[1] = {5'b01010, 11'd0};
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick(); tick();   // cycle 6
    chk("c6_valid", 32'(valid), 1);
    chk("c6_opcode", 32'(opcode), 32'h0a);
    tick();                                   // cycle 7
    chk("c7_illegal", 32'(illegal), 1);
    chk("c7_halted", 32'(halted), 1);
    chk("c7_pc", 32'(pc_addr), 1);
    chk("c7_count", 32'(count), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("c_restart_state", 32'(state), 32'(ST_FETCH));
    chk("c_restart_pc", 32'(pc_addr), 0);
    chk("c_restart_count", 32'(count), 0);
    chk("c_restart_illegal", 32'(illegal), 0);
    chk("c_restart_rd_en", 32'(rd_en), 1);

    // Asynchronous reset in the middle of EXEC.
    tick(); tick();                           // cycle 3 (EXEC)
    chk("d_exec_valid", 32'(valid), 1);
    rst = 1'b1;
    #1;
    chk("d_rst_state", 32'(state), 32'(ST_IDLE));
    chk("d_rst_valid", 32'(valid), 0);
    chk("d_rst_rd_en", 32'(rd_en), 0);
    chk("d_rst_count", 32'(count), 0);
    chk("d_rst_opcode", 32'(opcode), 0);
    chk("d_rst_halted", 32'(halted), 0);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("d_no_valid", 32'({valid, rd_en, state}), 0);
    end

    // PC wrap (PC_W=3) and count saturation (CNT_W=2).
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("w_pc_addr", 32'(pc_w), i % 8);
      tick(); tick(); tick();
    end
    chk("w_state", 32'(state_w), 32'(ST_FETCH));
    chk("w_count", 32'(cnt_w), 10);
    chk("s_count_sat", 32'(cnt_s), 3);
    chk("s_pc", 32'(pc_s), 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bip_fetch_ctrl.md
# bip_fetch_ctrl

Fetch/sequencing stage of the accumulator CPU, directly upstream of the instruction decoder. Holds the program counter (PC) and instruction register (IR), and reads the synchronous program memory. Presents the opcode to the decoder and the operand to the datapath, then advances the PC on the decoder's PC-write strobe. Stops on HALT or on an undefined opcode.

## Interface
Parameters:
- `N_OP`, 5, opcode width (IR upper bits)
- `N_OPERAND`, 11, operand width (IR lower bits)
- `PC_W`, 11, PC/program-address width
- `CNT_W`, 16, executed-instruction counter width

Ports:
- `i_clk`  in  1  single clock, rising edge
- `i_reset`  in  1  asynchronous, active-high reset
- `i_start`  in  1  run request; sampled only in IDLE or HALT
- `i_instr`  in  N_OP+N_OPERAND  program-memory read data, valid 1 cycle after `o_rd_en`
- `i_WrPC`  in  1  decoder PC-write strobe for the opcode on `o_OPcode`
- `o_pc_addr`  out  PC_W  program-memory address (= PC)
- `o_rd_en`  out  1  program-memory read enable
- `o_OPcode`  out  N_OP  IR[N_OP+N_OPERAND-1:N_OPERAND], to decoder
- `o_operand`  out  N_OPERAND  IR[N_OPERAND-1:0], to datapath
- `o_valid`  out  1  EXEC cycle; decoder outputs are to be committed
- `o_halted`  out  1  in HALT state
- `o_illegal`  out  1  sticky; halted on undefined opcode
- `o_instr_count`  out  CNT_W  instructions executed since start, saturating

## Operation
- States: IDLE, FETCH, DECODE, EXEC, HALT.
- IDLE: outputs quiet. When `i_start` = 1, clear PC, IR, count and `o_illegal`, then go to FETCH.
- FETCH: `o_rd_en` = 1, `o_pc_addr` = PC. Go to DECODE.
- DECODE: IR <= `i_instr`. Go to EXEC.
- EXEC: `o_valid` = 1. Decoder outputs are combinational on `o_OPcode`.
  - Opcode 0 (HALT): go to HALT. PC is not incremented and count is not incremented.
  - Opcode 1–7, `i_WrPC` = 1: PC <= PC+1 modulo 2^PC_W (wraps from all-ones to 0), count+1, go to FETCH.
  - Opcode 1–7, `i_WrPC` = 0: PC held, count+1, re-fetch the same address.
  - Opcode 8–31 (undefined): set `o_illegal`, go to HALT. PC and count are not incremented.
- HALT: `o_halted` = 1. PC, IR and count are frozen and readable. `i_start` = 1 restarts exactly as from IDLE.
- `i_start` in FETCH, DECODE or EXEC is ignored.
- Count saturates at 2^CNT_W-1 and does not wrap.

## Timing
- Reset (async assert, sync deassert by design):
  - state = IDLE;
  - PC, IR, count = 0;
  - all outputs 0: `o_pc_addr` = 0, `o_OPcode` = 0, `o_operand` = 0, `o_rd_en` = 0, `o_valid` = 0, `o_halted` = 0, `o_illegal` = 0, `o_instr_count` = 0.
- Reset mid-instruction aborts immediately. No memory read or `o_valid` occurs in the reset cycle.
- `i_start` high in cycle n (IDLE/HALT):
  - FETCH in n+1;
  - DECODE in n+2;
  - EXEC (`o_valid`) in n+3.
- Steady state: 3 cycles per instruction. `o_valid` is a 1-cycle pulse every 3rd cycle.
- `o_OPcode` and `o_operand` change only at the end of DECODE, so they are stable from EXEC through the next DECODE.
- PC update is visible on `o_pc_addr` in the FETCH cycle immediately following EXEC.
- `i_WrPC` is sampled only in EXEC.

## Structure
- Shared package `bip_pkg` holds:
  - opcode localparams HALT..SUBI (5'b00000–5'b00111) and `OP_LAST` = 7;
  - state encoding for IDLE/FETCH/DECODE/EXEC/HALT.
- The decoder uses the same package, so opcode values have a single source.
- One sub-module: `bip_pc`, a PC register with clear, increment enable and modulo wrap.
- The FSM, IR and counter live in the top module.

## Test plan
- **Straight-line program:** memory holds LOADI 5, ADDI 3, HALT; pulse start. Required:
  - `o_valid` at cycles 3, 6, 9;
  - `o_OPcode` sequence 3, 5, 0;
  - `o_operand` 5, 3;
  - `o_halted` = 1 from cycle 10;
  - count = 2, PC = 2.
- **PC wrap:** PC_W = 3, all 8 words ADDI. Required: `o_pc_addr` runs 7 → 0, execution continues, and count increments past 8.
- **Illegal opcode:** word 1 = 5'b01010. Required: `o_illegal` = 1, `o_halted` = 1, PC = 1, count = 1.
- **Hold on `i_WrPC` = 0:** force `i_WrPC` low for one EXEC. Required: the same address is re-fetched, and count still increments.
- **Start handling:**
  - `i_start` during FETCH/DECODE/EXEC: no effect.
  - `i_start` in HALT: PC = 0, count = 0, `o_illegal` cleared, FETCH next cycle.
- **Async reset mid-EXEC:**
  - all outputs 0 in the same cycle, state IDLE;
  - no `o_valid` until a new start;
  - count saturation checked with CNT_W = 2 (stays at 3).
